// File: rtl/quad_enc_decoder.sv
// Quadrature encoder front end: 2-FF synchronizer, optional per-pin debouncer
// (QDEC_DEBOUNCE_EN), priming, and detent decoding into one-cycle move/err pulses.
module quad_enc_decoder #(
    parameter int unsigned DEBOUNCE_CYCLES  = 50000,
    parameter int unsigned STEPS_PER_DETENT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enc_a,
    input  logic       enc_b,
    output logic [1:0] move,
    output logic       err
);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be in 1..65535");
    end
    if (STEPS_PER_DETENT != 1 && STEPS_PER_DETENT != 2 && STEPS_PER_DETENT != 4) begin : g_bad_steps
        $error("STEPS_PER_DETENT must be 1, 2 or 4");
    end

    localparam logic signed [3:0] STEP_POS = 4'(STEPS_PER_DETENT);
    localparam logic signed [3:0] STEP_NEG = -STEP_POS;

    typedef enum logic [1:0] {
        PR_FILL = 2'd0,
        PR_LOAD = 2'd1,
        PR_RUN  = 2'd2
    } prime_t;

    prime_t            prime_q, prime_d;
    logic              load, primed;
    logic [1:0]        sync1, sync2;   // bit 1 = A, bit 0 = B
    logic [1:0]        db;
    logic [1:0]        prev_q, prev_d;
    logic signed [2:0] sub_q, sub_d;
    logic signed [3:0] sub_up, sub_dn;
    logic [1:0]        step;
    logic [1:0]        move_d;
    logic              err_d;

    // Priming sequencer: one edge to fill sync1, then one load edge, then run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prime_q <= PR_FILL;
        else        prime_q <= prime_d;
    end

    always_comb begin
        prime_d = prime_q;
        case (prime_q)
            PR_FILL: prime_d = PR_LOAD;
            PR_LOAD: prime_d = PR_RUN;
            default: prime_d = PR_RUN;
        endcase
    end

    assign load   = (prime_q == PR_LOAD);
    assign primed = (prime_q == PR_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
        end else begin
            sync1 <= {enc_a, enc_b};
            sync2 <= sync1;
        end
    end

`ifdef QDEC_DEBOUNCE_EN
    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic [1:0][15:0] db_cnt;

    // On the load edge sync1 holds the value sync2 is about to take, so the
    // debounced state starts equal to the settled pins and no false step occurs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db     <= 2'b00;
            db_cnt <= '0;
        end else if (load) begin
            db     <= sync1;
            db_cnt <= '0;
        end else if (primed) begin
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == db[i]) begin
                    db_cnt[i] <= 16'd0;
                end else if (db_cnt[i] >= DB_LAST) begin
                    db[i]     <= sync2[i];
                    db_cnt[i] <= 16'd0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 16'd1;
                end
            end
        end
    end
`else
    assign db = sync2;
`endif

    // Position of a {A,B} state along the clockwise cycle 00 -> 10 -> 11 -> 01.
    function automatic logic [1:0] phase(input logic [1:0] ab);
        case (ab)
            2'b00:   phase = 2'd0;
            2'b10:   phase = 2'd1;
            2'b11:   phase = 2'd2;
            default: phase = 2'd3;
        endcase
    endfunction

    assign step   = phase(db) - phase(prev_q);
    assign sub_up = {sub_q[2], sub_q} + 4'sd1;
    assign sub_dn = {sub_q[2], sub_q} - 4'sd1;

    always_comb begin
        move_d = 2'b00;
        err_d  = 1'b0;
        sub_d  = sub_q;
        prev_d = prev_q;
        if (load) begin
            prev_d = sync1;
        end else if (primed && db != prev_q) begin
            prev_d = db;
            case (step)
                2'd1: begin
                    if (sub_up == STEP_POS) begin
                        move_d = 2'b10;
                        sub_d  = 3'sd0;
                    end else begin
                        sub_d = sub_up[2:0];
                    end
                end
                2'd3: begin
                    if (sub_dn == STEP_NEG) begin
                        move_d = 2'b01;
                        sub_d  = 3'sd0;
                    end else begin
                        sub_d = sub_dn[2:0];
                    end
                end
                default: begin
                    err_d = 1'b1;
                    sub_d = 3'sd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 2'b00;
            sub_q  <= 3'sd0;
            move   <= 2'b00;
            err    <= 1'b0;
        end else begin
            prev_q <= prev_d;
            sub_q  <= sub_d;
            move   <= move_d;
            err    <= err_d;
        end
    end

endmodule

// File: tb/tb_quad_enc_decoder.sv
// Bench for quad_enc_decoder: vector table, hand-written corner sequences and
// random pin activity, all checked cycle by cycle against a window-based model.
module tb_quad_enc_decoder;

    localparam int DEB   = 8;
    localparam int STEPS = 4;
`ifdef QDEC_DEBOUNCE_EN
    localparam int MODEL_DEB = DEB;
`else
    localparam int MODEL_DEB = 0;
`endif
    // Edges from the sampling edge to the pulse edge (sampling edge itself is edge 1 of 3+DEB).
    localparam int LAT = MODEL_DEB + 2;

    logic       clk;
    logic       rst_n;
    logic       enc_a;
    logic       enc_b;
    logic [1:0] move;
    logic       err;

    quad_enc_decoder #(
        .DEBOUNCE_CYCLES  (DEB),
        .STEPS_PER_DETENT (STEPS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .enc_a (enc_a),
        .enc_b (enc_b),
        .move  (move),
        .err   (err)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int cnt_cw   = 0;
    int cnt_ccw  = 0;
    int cnt_err  = 0;
    int cyc      = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    // ---------------- reference model + scoreboard ----------------
    logic [1:0] smp_q[$];   // pin samples, entry j-1 = sample taken at edge j after release
    logic [1:0] acc_q[$];   // accepted {A,B} after edge j
    logic [2:0] exp_q[$];   // expected {move, err}
    int         sub;

    function automatic int phase(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    always @(posedge clk) begin
        logic [2:0] e;
        logic [2:0] got;
        logic [2:0] want;
        logic [1:0] cur;
        logic [1:0] nxt;
        int         n;
        int         d;
        bit         all_new;
        cyc++;
        e = 3'b000;
        if (!rst_n) begin
            smp_q.delete();
            acc_q.delete();
            sub = 0;
        end else begin
            smp_q.push_back({enc_a, enc_b});
            n = smp_q.size();
            if (n == 1) begin
                acc_q.push_back(2'b00);
            end else if (n == 2) begin
                acc_q.push_back(smp_q[0]);
            end else begin
                cur = acc_q[n-2];
                nxt = cur;
                if (MODEL_DEB == 0) begin
                    nxt = smp_q[n-2];
                end else begin
                    // A pin flips once its last DEB samples (ending two edges ago) all disagree.
                    for (int i = 0; i < 2; i++) begin
                        if (n - 1 - MODEL_DEB >= 1) begin
                            all_new = 1'b1;
                            for (int j = n - 1 - MODEL_DEB; j <= n - 2; j++)
                                if (smp_q[j-1][i] == cur[i]) all_new = 1'b0;
                            if (all_new) nxt[i] = ~cur[i];
                        end
                    end
                end
                acc_q.push_back(nxt);
            end
            if (n >= 4 && acc_q[n-2] != acc_q[n-3]) begin
                d = (phase(acc_q[n-2]) - phase(acc_q[n-3]) + 4) % 4;
                if (d == 1) begin
                    sub++;
                    if (sub == STEPS) begin e = 3'b100; sub = 0; end
                end else if (d == 3) begin
                    sub--;
                    if (sub == -STEPS) begin e = 3'b010; sub = 0; end
                end else begin
                    e = 3'b001;
                    sub = 0;
                end
            end
        end
        exp_q.push_back(e);
        #2;
        got  = {move, err};
        want = exp_q.pop_front();
        check("cycle_out", int'(got), int'(want));
        if (move == 2'b10) cnt_cw++;
        if (move == 2'b01) cnt_ccw++;
        if (err)           cnt_err++;
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic a, input logic b, input int hold);
        @(negedge clk);
        enc_a = a;
        enc_b = b;
        repeat (hold - 1) @(negedge clk);
    endtask

    task automatic do_reset(input logic a, input logic b);
        @(negedge clk);
        rst_n = 1'b0;
        enc_a = a;
        enc_b = b;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        string name;
        logic  a;
        logic  b;
        int    hold;
        int    cw;
        int    ccw;
        int    er;
    } vec_t;

    vec_t tbl[$];

    task automatic apply(input vec_t v);
        int c0, d0, e0;
        c0 = cnt_cw; d0 = cnt_ccw; e0 = cnt_err;
        drive(v.a, v.b, v.hold);
        check({v.name, "_cw"},  cnt_cw  - c0, v.cw);
        check({v.name, "_ccw"}, cnt_ccw - d0, v.ccw);
        check({v.name, "_err"}, cnt_err - e0, v.er);
    endtask

    task automatic seg_counts(input string name, input int cw, input int ccw, input int er,
                              input int c0, input int d0, input int e0);
        check({name, "_cw"},  cnt_cw  - c0, cw);
        check({name, "_ccw"}, cnt_ccw - d0, ccw);
        check({name, "_err"}, cnt_err - e0, er);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int c0, d0, e0;
        int k, at;
        bit found;

        rst_n = 1'b0;
        enc_a = 1'b1;
        enc_b = 1'b1;

        tbl.push_back('{"cw_10",      1'b1, 1'b0, 20, 0, 0, 0});
        tbl.push_back('{"cw_11",      1'b1, 1'b1, 20, 0, 0, 0});
        tbl.push_back('{"cw_01",      1'b0, 1'b1, 20, 0, 0, 0});
        tbl.push_back('{"cw_00",      1'b0, 1'b0, 20, 1, 0, 0});
        tbl.push_back('{"ccw_01",     1'b0, 1'b1, 20, 0, 0, 0});
        tbl.push_back('{"ccw_11",     1'b1, 1'b1, 20, 0, 0, 0});
        tbl.push_back('{"ccw_10",     1'b1, 1'b0, 20, 0, 0, 0});
        tbl.push_back('{"ccw_00",     1'b0, 1'b0, 20, 0, 1, 0});
        tbl.push_back('{"rev_10",     1'b1, 1'b0, 20, 0, 0, 0});
        tbl.push_back('{"rev_11",     1'b1, 1'b1, 20, 0, 0, 0});
        tbl.push_back('{"rev_back10", 1'b1, 1'b0, 20, 0, 0, 0});
        tbl.push_back('{"rev_back00", 1'b0, 1'b0, 20, 0, 0, 0});
        tbl.push_back('{"zero_10",    1'b1, 1'b0, 20, 0, 0, 0});
        tbl.push_back('{"zero_11",    1'b1, 1'b1, 20, 0, 0, 0});
        tbl.push_back('{"zero_01",    1'b0, 1'b1, 20, 0, 0, 0});
        tbl.push_back('{"zero_00",    1'b0, 1'b0, 20, 1, 0, 0});
        tbl.push_back('{"glitch5",    1'b1, 1'b0,  5, 0, 0, 0});
        tbl.push_back('{"glitch5_00", 1'b0, 1'b0, 20, 0, 0, 0});
        tbl.push_back('{"glitch8",    1'b1, 1'b0,  8, 0, 0, 0});
        tbl.push_back('{"after8_11",  1'b1, 1'b1, 20, 0, 0, 0});
        tbl.push_back('{"after8_01",  1'b0, 1'b1, 20, 0, 0, 0});
        tbl.push_back('{"after8_00",  1'b0, 1'b0, 20, 1, 0, 0});
        tbl.push_back('{"illegal_11", 1'b1, 1'b1, 20, 0, 0, 1});
        tbl.push_back('{"post_01",    1'b0, 1'b1, 20, 0, 0, 0});
        tbl.push_back('{"post_00",    1'b0, 1'b0, 20, 0, 0, 0});
        tbl.push_back('{"post_10",    1'b1, 1'b0, 20, 0, 0, 0});
        tbl.push_back('{"post_11",    1'b1, 1'b1, 20, 1, 0, 0});

        // Resting at 11 through reset release must not produce a step.
        repeat (3) @(negedge clk);
        check("reset_move", int'(move), 0);
        check("reset_err",  int'(err), 0);
        c0 = cnt_cw; d0 = cnt_ccw; e0 = cnt_err;
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        seg_counts("rest11", 0, 0, 0, c0, d0, e0);

        do_reset(1'b0, 1'b0);
        drive(1'b0, 1'b0, 30);
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Exact latency of the detent-completing step.
        do_reset(1'b0, 1'b0);
        drive(1'b0, 1'b0, 30);
        drive(1'b1, 1'b0, 20);
        drive(1'b1, 1'b1, 20);
        drive(1'b0, 1'b1, 20);
        @(negedge clk);
        enc_a = 1'b0;
        enc_b = 1'b0;
        k = cyc + 1;
        found = 1'b0;
        at = -1;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk);
            #3;
            if (move == 2'b10) begin
                found = 1'b1;
                at = cyc;
            end
        end
        check("latency", found ? at - k : -1, LAT);
        drive(1'b0, 1'b0, 20);

        // Reset mid-detent discards the partial count.
        drive(1'b1, 1'b0, 20);
        drive(1'b1, 1'b1, 20);
        drive(1'b0, 1'b1, 20);
        do_reset(1'b0, 1'b0);
        drive(1'b0, 1'b0, 30);
        apply('{"rst_10", 1'b1, 1'b0, 20, 0, 0, 0});
        apply('{"rst_11", 1'b1, 1'b1, 20, 0, 0, 0});
        apply('{"rst_01", 1'b0, 1'b1, 20, 0, 0, 0});
        apply('{"rst_00", 1'b0, 1'b0, 20, 1, 0, 0});

        // Random pin activity, including bounce, illegal jumps and resets.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 14));
        end
        drive(enc_a, enc_b, 30);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
